// File: rtl/ir_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: widths,
// instruction field positions and the FSM state encoding.
package ir_fetch_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 8;
    localparam int IR_W   = 2 * BYTE_W;

    // Instruction field bit positions within ir (bit 11 is unused)
    localparam int OPCODE_HI     = 15;
    localparam int OPCODE_LO     = 12;
    localparam int ADDR_MODE_BIT = 10;
    localparam int RSEL_HI       = 9;
    localparam int RSEL_LO       = 8;
    localparam int ADDRESS_HI    = 7;
    localparam int ADDRESS_LO    = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_LO  = 3'd1,
        S_WAIT_LO = 3'd2,
        S_REQ_HI  = 3'd3,
        S_WAIT_HI = 3'd4,
        S_OUT     = 3'd5,
        S_DRAIN   = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/ir_fetch_ctrl_pc_counter.sv
// Fetch address counter: synchronous reset, load has priority over
// increment, otherwise hold. Wraps modulo 2^W.
module pc_counter #(
    parameter int         W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] pc
);

    // Reset > load > increment > hold
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_VAL;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Two-byte instruction fetch controller. Issues one byte read at a time,
// assembles a 16-bit instruction (low byte first) and hands it to the
// decoder with a valid/ready handshake. A redirect (pc_load) abandons the
// current fetch; a read already on the bus is drained and its data dropped.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | stopped, waiting for run
// S_REQ_LO  | read strobe for low byte
// S_WAIT_LO | waiting for low byte
// S_REQ_HI  | read strobe for high byte
// S_WAIT_HI | waiting for high byte
// S_OUT     | instruction presented, waiting for inst_ready
// S_DRAIN   | redirected with a read in flight, discard its response
module ir_fetch_ctrl
    import ir_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [BYTE_W-1:0] mem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [IR_W-1:0]   ir,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic              addr_mode,
    output logic [1:0]        rsel,
    output logic [7:0]        address,
    output logic              busy
);

    fetch_state_t state;
    logic         in_wait;
    logic         pc_inc;

    assign in_wait = (state == S_WAIT_LO) || (state == S_WAIT_HI);
    // A captured byte advances pc unless a redirect wins the same edge
    assign pc_inc  = in_wait && mem_valid && !pc_load;

    pc_counter #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pc_in),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Fetch sequencing and instruction register capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!pc_load && run)
                        state <= S_REQ_LO;
                end
                S_REQ_LO: state <= pc_load ? S_DRAIN : S_WAIT_LO;
                S_REQ_HI: state <= pc_load ? S_DRAIN : S_WAIT_HI;
                S_WAIT_LO: begin
                    if (pc_load)
                        state <= mem_valid ? S_REQ_LO : S_DRAIN;
                    else if (mem_valid) begin
                        ir[BYTE_W-1:0] <= mem_data;
                        state          <= S_REQ_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (pc_load)
                        state <= mem_valid ? S_REQ_LO : S_DRAIN;
                    else if (mem_valid) begin
                        ir[IR_W-1:BYTE_W] <= mem_data;
                        state             <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (pc_load)
                        state <= S_REQ_LO;
                    else if (inst_ready)
                        state <= run ? S_REQ_LO : S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_valid)
                        state <= S_REQ_LO;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd     = (state == S_REQ_LO) || (state == S_REQ_HI);
    assign mem_addr   = pc;
    assign inst_valid = (state == S_OUT);
    assign busy       = (state != S_IDLE);

    assign opcode    = ir[OPCODE_HI:OPCODE_LO];
    assign addr_mode = ir[ADDR_MODE_BIT];
    assign rsel      = ir[RSEL_HI:RSEL_LO];
    assign address   = ir[ADDRESS_HI:ADDRESS_LO];

endmodule
